// File: rtl/vidbuf_fill.sv
// Rectangle-fill engine: takes one fill command and rasterises it into
// single-pixel frame buffer writes, one per clock, column fastest.
module vidbuf_fill #(
  parameter int X_WIDTH    = 9,
  parameter int Y_WIDTH    = 8,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_WIDTH-1:0]    cmd_x0,
  input  logic [Y_WIDTH-1:0]    cmd_y0,
  input  logic [X_WIDTH-1:0]    cmd_x1,
  input  logic [Y_WIDTH-1:0]    cmd_y1,
  input  logic [DATA_WIDTH-1:0] cmd_color,
  input  logic                  pause,
  input  logic                  abort,
  output logic [X_WIDTH-1:0]    x,
  output logic [Y_WIDTH-1:0]    y,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  we,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state, w_state_next;
  logic [X_WIDTH-1:0]    r_xmin, r_xmax, r_cx;
  logic [Y_WIDTH-1:0]    r_ymin, r_ymax, r_cy;
  logic [DATA_WIDTH-1:0] r_color;
  logic                  r_fin;
  logic [X_WIDTH-1:0]    r_x;
  logic [Y_WIDTH-1:0]    r_y;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_we, r_busy, r_done, r_cmd_ready;

  logic                  w_accept, w_emit, w_last_px;
  logic [X_WIDTH-1:0]    w_xmin, w_xmax, w_cx, w_cx_next, w_x_next;
  logic [Y_WIDTH-1:0]    w_ymin, w_ymax, w_cy, w_cy_next, w_y_next;
  logic [DATA_WIDTH-1:0] w_color, w_data_next;
  logic                  w_fin_next, w_we_next, w_busy_next, w_done_next, w_ready_next;

  always_comb begin
    w_accept = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;

    w_xmin  = r_xmin;
    w_xmax  = r_xmax;
    w_ymin  = r_ymin;
    w_ymax  = r_ymax;
    w_color = r_color;
    w_cx    = r_cx;
    w_cy    = r_cy;
    // The accepting edge already emits the first pixel, so the normalised
    // corners are used directly rather than waiting for them to be registered.
    if (w_accept) begin
      w_xmin  = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
      w_xmax  = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
      w_ymin  = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
      w_ymax  = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
      w_color = cmd_color;
      w_cx    = w_xmin;
      w_cy    = w_ymin;
    end

    w_emit    = !pause && (w_accept || ((r_state == S_RUN) && !r_fin && !abort));
    w_last_px = (w_cx == w_xmax) && (w_cy == w_ymax);

    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_data_next  = r_data;
    w_we_next    = 1'b0;
    w_done_next  = 1'b0;
    w_busy_next  = r_busy;
    w_ready_next = r_cmd_ready;
    w_fin_next   = r_fin;
    w_cx_next    = w_cx;
    w_cy_next    = w_cy;

    case (r_state)
      S_IDLE: begin
        w_ready_next = 1'b1;
        w_busy_next  = 1'b0;
        if (w_accept) begin
          w_state_next = S_RUN;
          w_ready_next = 1'b0;
          w_busy_next  = 1'b1;
          w_fin_next   = 1'b0;
        end
      end
      S_RUN: begin
        // r_fin marks that the final pixel is on the outputs this cycle.
        if (abort) begin
          w_state_next = S_IDLE;
          w_ready_next = 1'b1;
          w_busy_next  = 1'b0;
        end else if (r_fin) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
          w_ready_next = 1'b1;
          w_busy_next  = 1'b0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_emit) begin
      w_x_next    = w_cx;
      w_y_next    = w_cy;
      w_data_next = w_color;
      w_we_next   = 1'b1;
      w_fin_next  = w_last_px;
      if (w_cx == w_xmax) begin
        w_cx_next = w_xmin;
        w_cy_next = w_cy + 1'b1;
      end else begin
        w_cx_next = w_cx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_xmin      <= '0;
      r_xmax      <= '0;
      r_ymin      <= '0;
      r_ymax      <= '0;
      r_color     <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_fin       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_data      <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_xmin      <= w_xmin;
      r_xmax      <= w_xmax;
      r_ymin      <= w_ymin;
      r_ymax      <= w_ymax;
      r_color     <= w_color;
      r_cx        <= w_cx_next;
      r_cy        <= w_cy_next;
      r_fin       <= w_fin_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_data      <= w_data_next;
      r_we        <= w_we_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_cmd_ready <= w_ready_next;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign x         = r_x;
  assign y         = r_y;
  assign data      = r_data;
  assign we        = r_we;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_vidbuf_fill.sv
// Bench for vidbuf_fill: expected pixel stream is generated from the command
// rectangle and compared in order by a monitor on the falling edge.
module tb_vidbuf_fill;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int DW = 24;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [XW-1:0] cmd_x0 = '0, cmd_x1 = '0;
  logic [YW-1:0] cmd_y0 = '0, cmd_y1 = '0;
  logic [DW-1:0] cmd_color = '0;
  logic          cmd_ready, we, busy, done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [DW-1:0] data;

  vidbuf_fill #(.X_WIDTH(XW), .Y_WIDTH(YW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .pause(pause), .abort(abort),
    .x(x), .y(y), .data(data), .we(we), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [DW-1:0] pd;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   pend_done = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  // Reference: every pixel of the normalised rectangle, rows outer, columns inner.
  task automatic model_push(input int x0, input int y0, input int x1, input int y1,
                            input logic [DW-1:0] c);
    int xl, xh, yl, yh;
    pix_t p;
    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
    for (int yy = yl; yy <= yh; yy++) begin
      for (int xx = xl; xx <= xh; xx++) begin
        p.px = XW'(xx);
        p.py = YW'(yy);
        p.pd = c;
        exp_q.push_back(p);
      end
    end
    pend_done++;
  endtask

  task automatic model_abort();
    exp_q.delete();
    if (pend_done > 0) pend_done--;
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (we) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got write at (%0d,%0d), expected none", x, y);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel", {x, y, data}, {mon_e.px, mon_e.py, mon_e.pd});
          check("busy_during_write", 64'(busy), 64'd1);
        end
      end
      if (done) begin
        check("done_expected", 64'(pend_done > 0), 64'd1);
        check("done_after_last_write", 64'(exp_q.size()), 64'd0);
        check("done_cycle_flags", {busy, cmd_ready, we}, 3'b010);
        if (pend_done > 0) pend_done--;
      end
    end
  end

  task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                          input logic [DW-1:0] c, input bit hold);
    int i;
    i = 0;
    while (!cmd_ready && i < 2000) begin
      @(posedge CLK); #1;
      i++;
    end
    if (!cmd_ready) fail_now("cmd_ready_wait");
    cmd_x0 = XW'(x0); cmd_y0 = YW'(y0);
    cmd_x1 = XW'(x1); cmd_y1 = YW'(y1);
    cmd_color = c;
    cmd_valid = 1'b1;
    @(posedge CLK);
    model_push(x0, y0, x1, y1, c);
    #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_x0 = XW'($urandom); cmd_y0 = YW'($urandom);
      cmd_x1 = XW'($urandom); cmd_y1 = YW'($urandom);
      cmd_color = DW'($urandom);
    end
  endtask

  // Returns at +1 after the done edge; nc counts cycles from acceptance to done.
  task automatic run_fill(input int x0, input int y0, input int x1, input int y1,
                          input logic [DW-1:0] c, input int pause_pct, input int abort_pct,
                          output int nw, output int nc, output bit aborted);
    bit got;
    send_cmd(x0, y0, x1, y1, c, 1'b0);
    nw = 0; nc = 0; aborted = 1'b0; got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      nc++;
      if (done) begin got = 1'b1; break; end
      if (we) nw++;
      pause = ($urandom_range(99) < pause_pct);
      abort = ($urandom_range(99) < abort_pct);
      @(posedge CLK); #1;
      if (abort) begin
        abort = 1'b0;
        pause = 1'b0;
        check("abort_stops", {we, done, busy, cmd_ready}, 4'b0001);
        model_abort();
        aborted = 1'b1;
        got = 1'b1;
        break;
      end
    end
    pause = 1'b0;
    abort = 1'b0;
    if (!got) fail_now("done_wait");
  endtask

  task automatic wait_done(output int nw);
    bit got;
    nw = 0; got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge CLK); #1;
      if (done) begin got = 1'b1; break; end
      if (we) nw++;
    end
    if (!got) fail_now("done_wait");
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int nw, nc, nw2, cnt, i;
    bit ab;
    int rx0, rx1, ry0, ry1, dx, dy, area;

    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", {x, y, data, we, busy, done, cmd_ready}, 64'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("ready_after_reset", {cmd_ready, busy, we, done}, 4'b1000);

    // Single pixel: write in the cycle after acceptance, done one cycle later.
    send_cmd(5, 7, 5, 7, 24'hFF0000, 1'b0);
    check("first_write_latency", {we, x, y, data}, {1'b1, 9'd5, 8'd7, 24'hFF0000});
    @(posedge CLK); #1;
    check("single_done", {done, we, busy, cmd_ready}, 4'b1001);
    @(posedge CLK); #1;
    check("done_one_cycle", 64'(done), 64'd0);

    run_fill(12, 4, 10, 3, 24'h00FF00, 0, 0, nw, nc, ab);
    check("swap_writes", 64'(nw), 64'd6);
    check("swap_cycles", 64'(nc), 64'd7);

    // Pause for three edges after the second write.
    send_cmd(0, 0, 3, 0, 24'h0000FF, 1'b0);
    check("pause_w0", {we, x}, {1'b1, 9'd0});
    @(posedge CLK); #1;
    check("pause_w1", {we, x}, {1'b1, 9'd1});
    pause = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      check("pause_hold", {we, x, y}, {1'b0, 9'd1, 8'd0});
    end
    pause = 1'b0;
    wait_done(nw2);
    check("pause_total_writes", 64'(2 + nw2), 64'd4);

    run_fill(511, 255, 511, 255, 24'hABCDEF, 0, 0, nw, nc, ab);
    check("corner_writes", 64'(nw), 64'd1);
    check("corner_cycles", 64'(nc), 64'd2);
    run_fill(0, 255, 511, 254, 24'h000000, 0, 0, nw, nc, ab);
    check("fullwidth_writes", 64'(nw), 64'd1024);
    check("fullwidth_cycles", 64'(nc), 64'd1025);
    run_fill(511, 1, 500, 0, 24'h102030, 0, 0, nw, nc, ab);
    check("rightedge_writes", 64'(nw), 64'd24);

    // Abort on the 10th write of a 20x20 fill.
    send_cmd(100, 50, 119, 69, 24'h55AA55, 1'b0);
    cnt = 1; i = 0;
    while (cnt < 10 && i < 100) begin
      @(posedge CLK); #1;
      if (we) cnt++;
      i++;
    end
    check("abort_reached_10", 64'(cnt), 64'd10);
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    check("abort_stop", {we, done, busy, cmd_ready}, 4'b0001);
    model_abort();
    @(posedge CLK); #1;
    check("abort_no_done", {we, done}, 2'b00);
    run_fill(3, 3, 5, 5, 24'h0F0F0F, 0, 0, nw, nc, ab);
    check("after_abort_writes", 64'(nw), 64'd9);
    check("after_abort_cycles", 64'(nc), 64'd10);

    // Asynchronous reset in the middle of a fill.
    send_cmd(0, 0, 19, 19, 24'h777777, 1'b0);
    repeat (5) @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check("async_reset", {x, y, data, we, busy, done, cmd_ready}, 64'd0);
    model_abort();
    @(posedge CLK); #1;
    check("reset_held", {x, y, data, we, busy, done, cmd_ready}, 64'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("ready_after_mid_reset", {cmd_ready, done}, 2'b10);
    run_fill(7, 8, 9, 8, 24'hC0FFEE, 0, 0, nw, nc, ab);
    check("after_reset_writes", 64'(nw), 64'd3);

    // Back-to-back: a differing command held valid throughout the first fill.
    send_cmd(2, 2, 4, 3, 24'h123456, 1'b1);
    cmd_x0 = 9'd40; cmd_y0 = 8'd10; cmd_x1 = 9'd37; cmd_y1 = 8'd11;
    cmd_color = 24'h654321;
    nw = 0; ab = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin ab = 1'b1; break; end
      if (we) nw++;
      @(posedge CLK); #1;
    end
    if (!ab) fail_now("b2b_done_wait");
    check("b2b_first_writes", 64'(nw), 64'd6);
    check("b2b_done_ready", {done, cmd_ready}, 2'b11);
    @(posedge CLK);
    model_push(40, 10, 37, 11, 24'h654321);
    #1;
    cmd_valid = 1'b0;
    check("b2b_second_first_write", {we, x, y}, {1'b1, 9'd37, 8'd10});
    wait_done(nw2);
    check("b2b_second_writes", 64'(1 + nw2), 64'd8);

    // Randomised small rectangles with pause and occasional abort.
    for (int t = 0; t < 40; t++) begin
      rx0 = $urandom_range(511); dx = $urandom_range(7);
      ry0 = $urandom_range(255); dy = $urandom_range(5);
      if ($urandom_range(1) == 1) rx1 = (rx0 + dx > 511) ? 511 : rx0 + dx;
      else                        rx1 = (rx0 < dx) ? 0 : rx0 - dx;
      if ($urandom_range(1) == 1) ry1 = (ry0 + dy > 255) ? 255 : ry0 + dy;
      else                        ry1 = (ry0 < dy) ? 0 : ry0 - dy;
      area = ((rx0 > rx1) ? rx0 - rx1 + 1 : rx1 - rx0 + 1) *
             ((ry0 > ry1) ? ry0 - ry1 + 1 : ry1 - ry0 + 1);
      run_fill(rx0, ry0, rx1, ry1, DW'($urandom), 25, (t % 4 == 3) ? 8 : 0, nw, nc, ab);
      if (!ab) check("rand_writes", 64'(nw), 64'(area));
    end

    repeat (3) @(posedge CLK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_balance", 64'(pend_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
